// File: rtl/icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder
//
// Responder end of the instruction-fetch cache port. A fetch request carries a
// PC. The block answers with a one-cycle response pulse and one aligned
// 16-byte line of four instructions. Lines live in a small direct-mapped cache.
// A miss refills the line from instruction memory in four single-word beats.
//
// Ports
//   iClk             clock
//   iResetn          asynchronous active-low reset
//   toCache_req      fetch request (level, may drop at any time)
//   toCache_pc       fetch PC, bits [3:0] ignored
//   fromCache_resp   one-cycle response pulse
//   fromCache_instr  line data, word k = address base+4k
//   iFlush           invalidate every line
//   oMemReq          memory read request, held until iMemAck
//   oMemAddr         word address of the current refill beat
//   iMemAck          beat accepted, iMemData valid this cycle
//   iMemData         memory read data
// -----------------------------------------------------------------------------
module icache_fetch_responder #(
  parameter int PCW  = 32,
  parameter int IW   = 32,
  parameter int IDXW = 4
) (
  input  logic              iClk,
  input  logic              iResetn,
  input  logic              toCache_req,
  input  logic [PCW-1:0]    toCache_pc,
  output logic              fromCache_resp,
  output logic [IW*4-1:0]   fromCache_instr,
  input  logic              iFlush,
  output logic              oMemReq,
  output logic [PCW-1:0]    oMemAddr,
  input  logic              iMemAck,
  input  logic [IW-1:0]     iMemData
);

  localparam int LINES = 2 ** IDXW;
  localparam int TW    = PCW - 4 - IDXW;
  localparam int LW    = IW * 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;

  // Line address of the captured request (PC without the byte-in-line bits).
  logic [PCW-5:0]     line_pc_r;
  logic [IDXW-1:0]    idx_s;
  logic [TW-1:0]      tag_s;

  logic [LINES-1:0]   valid_r;
  logic [TW-1:0]      tag_mem [LINES];
  logic [LW-1:0]      data_mem [LINES];

  // Only the first three beats need buffering; the fourth is taken straight
  // from iMemData on the cycle the line is written.
  logic [IW-1:0]      buf0_r;
  logic [IW-1:0]      buf1_r;
  logic [IW-1:0]      buf2_r;

  logic [1:0]         beat_r;
  logic               flush_pend_r;
  logic [LW-1:0]      instr_r;
  logic               mem_req_r;
  logic [PCW-1:0]     mem_addr_r;

  logic               hit_s;
  logic               ack_s;
  logic               last_ack_s;
  logic [LW-1:0]      fill_line_s;
  logic               unused_pc_bits_s;

  assign idx_s       = line_pc_r[IDXW-1:0];
  assign tag_s       = line_pc_r[PCW-5:IDXW];

  // A flush in the same cycle as the lookup wins, so the lookup misses.
  assign hit_s       = valid_r[idx_s] && (tag_mem[idx_s] == tag_s) && !iFlush;

  assign ack_s       = (state_r == ST_FILL) && iMemAck;
  assign last_ack_s  = ack_s && (beat_r == 2'd3);
  assign fill_line_s = {iMemData, buf2_r, buf1_r, buf0_r};

  // Byte-in-line bits of the PC are never used.
  assign unused_pc_bits_s = ^toCache_pc[3:0];

  // The pulse is gated by the live request so a fetcher that dropped its
  // request (e.g. its fifo filled up) never sees a response.
  assign fromCache_resp  = (state_r == ST_RESP) && toCache_req;
  assign fromCache_instr = instr_r;
  assign oMemReq         = mem_req_r;
  assign oMemAddr        = mem_addr_r;

  // State register.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; RESP always returns to IDLE so the next PC is sampled fresh.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (toCache_req) begin
          state_s = ST_LOOKUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_FILL: begin
        if (last_ack_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Request capture, memory request/address, beat counter and output line.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      line_pc_r  <= {(PCW-4){1'b0}};
      mem_req_r  <= 1'b0;
      mem_addr_r <= {PCW{1'b0}};
      beat_r     <= 2'd0;
      instr_r    <= {LW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (toCache_req) begin
            line_pc_r <= toCache_pc[PCW-1:4];
          end
        end
        ST_LOOKUP: begin
          if (hit_s) begin
            instr_r <= data_mem[idx_s];
          end else begin
            mem_req_r  <= 1'b1;
            mem_addr_r <= {line_pc_r, 4'h0};
          end
        end
        ST_FILL: begin
          if (iMemAck) begin
            if (beat_r == 2'd3) begin
              mem_req_r <= 1'b0;
              beat_r    <= 2'd0;
              instr_r   <= fill_line_s;
            end else begin
              beat_r     <= beat_r + 2'd1;
              mem_addr_r <= {line_pc_r, beat_r + 2'd1, 2'b00};
            end
          end
        end
        ST_RESP: begin
          beat_r <= 2'd0;
        end
        default: begin
          beat_r <= 2'd0;
        end
      endcase
    end
  end

  // Valid bits: a flush clears them all and beats any same-cycle line write.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      valid_r <= {LINES{1'b0}};
    end else if (iFlush) begin
      valid_r <= {LINES{1'b0}};
    end else if (last_ack_s && !flush_pend_r) begin
      valid_r[idx_s] <= 1'b1;
    end
  end

  // Flush seen during a refill: the line is still returned but not kept valid.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      flush_pend_r <= 1'b0;
    end else if (state_r == ST_RESP) begin
      flush_pend_r <= 1'b0;
    end else if (iFlush && (state_r == ST_FILL)) begin
      flush_pend_r <= 1'b1;
    end
  end

  // Refill line buffer for the first three beats (no reset needed).
  always_ff @(posedge iClk) begin
    if (ack_s) begin
      case (beat_r)
        2'd0:    buf0_r <= iMemData;
        2'd1:    buf1_r <= iMemData;
        2'd2:    buf2_r <= iMemData;
        default: ;
      endcase
    end
  end

  // Tag and data arrays; written once when the final beat arrives.
  always_ff @(posedge iClk) begin
    if (last_ack_s) begin
      tag_mem[idx_s]  <= tag_s;
      data_mem[idx_s] <= fill_line_s;
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
module tb_icache_fetch_responder;

  logic          iClk = 1'b0;
  logic          iResetn;
  logic          toCache_req;
  logic [31:0]   toCache_pc;
  logic          fromCache_resp;
  logic [127:0]  fromCache_instr;
  logic          iFlush;
  logic          oMemReq;
  logic [31:0]   oMemAddr;
  logic          iMemAck;
  logic [31:0]   iMemData;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int mem_gap = 0;
  int wait_cnt = 0;
  logic [31:0] addr_log [$];

  bit           got;
  logic [127:0] line;
  int           lat;
  int           beats;
  int           a0;
  int           nresp;
  int           last;

  always #5 iClk = ~iClk;

  icache_fetch_responder #(.PCW(32), .IW(32), .IDXW(4)) dut (
    .iClk            (iClk),
    .iResetn         (iResetn),
    .toCache_req     (toCache_req),
    .toCache_pc      (toCache_pc),
    .fromCache_resp  (fromCache_resp),
    .fromCache_instr (fromCache_instr),
    .iFlush          (iFlush),
    .oMemReq         (oMemReq),
    .oMemAddr        (oMemAddr),
    .iMemAck         (iMemAck),
    .iMemData        (iMemData)
  );

  // Memory contents: 0x100..0x10C hold 0xA0..0xA3, elsewhere a tagged address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + {28'd0, a[3:2]};
    else return {16'hD00D, a[15:0]};
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] base);
    return {mem_word(base + 32'd12), mem_word(base + 32'd8),
            mem_word(base + 32'd4), mem_word(base)};
  endfunction

  // Instruction memory model: acks after mem_gap idle cycles per beat.
  always @(negedge iClk) begin
    if (!iResetn || !oMemReq) begin
      iMemAck = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt < mem_gap) begin
      iMemAck = 1'b0;
      wait_cnt++;
    end else begin
      iMemAck = 1'b1;
      iMemData = mem_word(oMemAddr);
      wait_cnt = 0;
      ack_cnt++;
      addr_log.push_back(oMemAddr);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch; optional flush/drop when the ack count since start reaches a value.
  task automatic fetch(input logic [31:0] pc, input int flush_at, input int drop_at,
                       input int max_cyc, output bit g, output logic [127:0] ln,
                       output int lt, output int bt);
    int s0;
    bit flushed;
    @(negedge iClk); #1;
    s0 = ack_cnt;
    g = 1'b0;
    lt = 0;
    ln = 128'd0;
    flushed = 1'b0;
    toCache_req = 1'b1;
    toCache_pc = pc;
    while (!g && lt < max_cyc) begin
      @(negedge iClk); #1;
      lt++;
      iFlush = 1'b0;
      if (fromCache_resp) begin
        g = 1'b1;
        ln = fromCache_instr;
      end else begin
        if (flush_at >= 0 && !flushed && (ack_cnt - s0) == flush_at) begin
          iFlush = 1'b1;
          flushed = 1'b1;
        end
        if (drop_at >= 0 && (ack_cnt - s0) == drop_at) toCache_req = 1'b0;
      end
    end
    toCache_req = 1'b0;
    iFlush = 1'b0;
    bt = ack_cnt - s0;
  endtask

  initial begin
    iResetn = 1'b0;
    toCache_req = 1'b0;
    toCache_pc = 32'd0;
    iFlush = 1'b0;
    iMemAck = 1'b0;
    iMemData = 32'd0;
    repeat (2) @(negedge iClk);
    #1;
    check("rst_resp", fromCache_resp, 0);
    check("rst_instr", fromCache_instr, 0);
    check("rst_memreq", oMemReq, 0);
    check("rst_memaddr", oMemAddr, 0);
    iResetn = 1'b1;

    // Cold miss with single-cycle acks.
    addr_log.delete();
    fetch(32'h100, -1, -1, 60, got, line, lat, beats);
    check("cold_got", got, 1);
    check("cold_line", line, 128'h000000A3_000000A2_000000A1_000000A0);
    check("cold_lat", lat, 6);
    check("cold_beats", beats, 4);
    check("cold_nlog", addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("cold_addr%0d", i), addr_log[i], 32'h100 + 32'(4 * i));

    // Hit within the same line.
    fetch(32'h108, -1, -1, 60, got, line, lat, beats);
    check("hit_got", got, 1);
    check("hit_line", line, 128'h000000A3_000000A2_000000A1_000000A0);
    check("hit_lat", lat, 2);
    check("hit_beats", beats, 0);

    // Same index, different tag: replaces the line.
    fetch(32'h200, -1, -1, 60, got, line, lat, beats);
    check("repl_line", line, exp_line(32'h200));
    check("repl_beats", beats, 4);
    fetch(32'h100, -1, -1, 60, got, line, lat, beats);
    check("repl_old_beats", beats, 4);
    check("repl_old_line", line, 128'h000000A3_000000A2_000000A1_000000A0);

    // Stalled acks: three idle cycles before every beat.
    mem_gap = 3;
    fetch(32'h700, -1, -1, 60, got, line, lat, beats);
    mem_gap = 0;
    check("stall_line", line, exp_line(32'h700));
    check("stall_lat", lat, 18);
    check("stall_beats", beats, 4);

    // Populate four lines, then back-to-back hits with req held.
    for (int i = 0; i < 4; i++) begin
      fetch(32'h600 + 32'(16 * i), -1, -1, 60, got, line, lat, beats);
      check($sformatf("pop_line%0d", i), line, exp_line(32'h600 + 32'(16 * i)));
    end
    a0 = ack_cnt;
    @(negedge iClk); #1;
    toCache_req = 1'b1;
    toCache_pc = 32'h600;
    nresp = 0;
    last = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge iClk); #1;
      if (fromCache_resp) begin
        check($sformatf("b2b_line%0d", nresp), fromCache_instr, exp_line(toCache_pc));
        check($sformatf("b2b_gap%0d", nresp), c - last, (nresp == 0) ? 2 : 3);
        last = c;
        nresp++;
        toCache_pc = toCache_pc + 32'd16;
        if (nresp == 4) toCache_req = 1'b0;
      end
    end
    check("b2b_count", nresp, 4);
    check("b2b_beats", ack_cnt - a0, 0);

    // Request dropped after two acks: refill completes, no response.
    fetch(32'h300, -1, 2, 12, got, line, lat, beats);
    check("drop_got", got, 0);
    check("drop_beats", beats, 4);
    fetch(32'h300, -1, -1, 60, got, line, lat, beats);
    check("drop_rehit_beats", beats, 0);
    check("drop_rehit_lat", lat, 2);
    check("drop_rehit_line", line, exp_line(32'h300));

    // Flush during LOOKUP forces a miss; the refilled line is then valid.
    fetch(32'h300, 0, -1, 60, got, line, lat, beats);
    check("flk_beats", beats, 4);
    check("flk_line", line, exp_line(32'h300));
    fetch(32'h300, -1, -1, 60, got, line, lat, beats);
    check("flk_rehit_beats", beats, 0);

    // Flush mid-refill: data returned, line not kept.
    fetch(32'h400, 1, -1, 60, got, line, lat, beats);
    check("ffl_got", got, 1);
    check("ffl_line", line, exp_line(32'h400));
    fetch(32'h400, -1, -1, 60, got, line, lat, beats);
    check("ffl_remiss_beats", beats, 4);
    fetch(32'h400, -1, -1, 60, got, line, lat, beats);
    check("ffl_hit_beats", beats, 0);

    // Flush while idle invalidates a line that was hitting.
    @(negedge iClk); #1;
    iFlush = 1'b1;
    @(negedge iClk); #1;
    iFlush = 1'b0;
    fetch(32'h400, -1, -1, 60, got, line, lat, beats);
    check("fidle_beats", beats, 4);
    check("fidle_line", line, exp_line(32'h400));

    // Reset mid-refill after one accepted beat.
    @(negedge iClk); #1;
    a0 = ack_cnt;
    toCache_req = 1'b1;
    toCache_pc = 32'h500;
    for (int c = 0; c < 20 && (ack_cnt - a0) < 1; c++) begin
      @(negedge iClk); #1;
    end
    check("rmid_ack_seen", ack_cnt - a0, 1);
    @(posedge iClk); #1;
    iResetn = 1'b0;
    #1;
    check("rmid_memreq", oMemReq, 0);
    check("rmid_resp", fromCache_resp, 0);
    check("rmid_memaddr", oMemAddr, 0);
    toCache_req = 1'b0;
    @(negedge iClk); #1;
    iResetn = 1'b1;
    addr_log.delete();
    fetch(32'h400, -1, -1, 60, got, line, lat, beats);
    check("rpost_got", got, 1);
    check("rpost_beats", beats, 4);
    check("rpost_lat", lat, 6);
    check("rpost_line", line, exp_line(32'h400));
    check("rpost_addr0", addr_log[0], 32'h400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
